// File: rtl/stacking_pkg.sv
// stacking_pkg: shared constants, derived widths and FSM state type for the
// stacking outer loop and its helpers.
package stacking_pkg;

  localparam int IFM_SIZE_Y          = 7;
  localparam int FILTER_SIZE_Y       = 3;
  localparam int FILTER_SIZE_X       = 3;
  localparam int PREFIX_SUM_SIZE     = 8;
  localparam int DIVIDED_CHANNEL_NUM = 32;
  localparam int CHUNK_NUM_MAX       = 16;

  // Output rows produced by a valid (unpadded) vertical convolution.
  localparam int OUT_Y = IFM_SIZE_Y - FILTER_SIZE_Y + 1;

  localparam int Y_W     = $clog2(IFM_SIZE_Y) + 1;
  localparam int CHUNK_W = $clog2(CHUNK_NUM_MAX) + 1;
  localparam int SUB_W   = $clog2(DIVIDED_CHANNEL_NUM) + 1;
  localparam int STEP_W  = $clog2(IFM_SIZE_Y * DIVIDED_CHANNEL_NUM / PREFIX_SUM_SIZE + 1) + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    ADV   = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/stacking_outer_loop_fil_window_calc.sv
// fil_window_calc: maps an IFM row to the range of filter rows that
// contribute to a legal output row. Purely combinational.
module fil_window_calc
  import stacking_pkg::*;
(
  input  logic [Y_W-1:0] y,
  output logic [Y_W-1:0] fil_start,
  output logic [Y_W-1:0] fil_last
);

  localparam logic [Y_W:0] START_OFS = (Y_W+1)'(OUT_Y - 1);
  localparam logic [Y_W:0] LAST_MAX  = (Y_W+1)'(FILTER_SIZE_Y - 1);

  logic [Y_W:0] y_ext;

  // Clamp both window edges; one extra bit keeps the subtraction from wrapping.
  always_comb begin
    y_ext     = {1'b0, y};
    fil_start = '0;
    if (y_ext > START_OFS) fil_start = Y_W'(y_ext - START_OFS);
    fil_last = Y_W'(LAST_MAX);
    if (y_ext < LAST_MAX) fil_last = y;
  end

endmodule

// File: rtl/stacking_outer_loop.sv
// stacking_outer_loop: walks chunks (outer) and IFM rows (inner) of a layer,
// launching one inner loop per (chunk, row) and holding its indices until the
// inner loop finishes. Optional macro OUTER_LOOP_STALL_CNT_EN adds a
// saturating count of cycles spent waiting on the inner loop.
module stacking_outer_loop
  import stacking_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               layer_start_i,
  input  logic [CHUNK_W-1:0] chunk_num_i,
  input  logic [SUB_W-1:0]   sub_channel_size_i,
  input  logic               inner_loop_finish_i,
  output logic               inner_loop_start_o,
  output logic [Y_W-1:0]     ifm_loop_y_idx_o,
  output logic [Y_W-1:0]     fil_loop_y_idx_start_o,
  output logic [Y_W-1:0]     fil_loop_y_idx_last_o,
  output logic [STEP_W-1:0]  fil_loop_y_step_o,
  output logic [SUB_W-1:0]   sub_channel_size_o,
  output logic [CHUNK_W-1:0] chunk_idx_o,
  output logic               busy_o,
  output logic               layer_done_o
`ifdef OUTER_LOOP_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt_o
`endif
);

  state_e             state_q, state_d;
  logic [Y_W-1:0]     y_q;
  logic [CHUNK_W-1:0] chunk_q;
  logic [CHUNK_W-1:0] chunk_num_q;
  logic [STEP_W-1:0]  step_q;
  logic [SUB_W-1:0]   sub_q;

  logic [CHUNK_W-1:0] chunk_num_sat;
  logic [CHUNK_W-1:0] chunk_inc;
  logic [STEP_W-1:0]  step_calc;
  logic               y_last;
  logic               accept_start;

  // Capture-time arithmetic: chunk saturation and sparsemap step (ceil division).
  always_comb begin
    chunk_num_sat = chunk_num_i;
    if (chunk_num_i > CHUNK_W'(CHUNK_NUM_MAX)) chunk_num_sat = CHUNK_W'(CHUNK_NUM_MAX);
    step_calc = STEP_W'(1);
    if (sub_channel_size_i != '0)
      step_calc = STEP_W'((FILTER_SIZE_X * 32'(sub_channel_size_i) + PREFIX_SUM_SIZE - 1)
                          / PREFIX_SUM_SIZE);
    chunk_inc    = chunk_q + 1'b1;
    y_last       = (y_q == Y_W'(IFM_SIZE_Y - 1));
    accept_start = (state_q == IDLE) && layer_start_i;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (layer_start_i) state_d = (chunk_num_sat == '0) ? DONE : START;
      START:   state_d = WAIT;
      WAIT:    if (inner_loop_finish_i) state_d = ADV;
      ADV:     state_d = (y_last && (chunk_inc == chunk_num_q)) ? DONE : START;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, captured layer configuration and loop indices.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      y_q         <= '0;
      chunk_q     <= '0;
      chunk_num_q <= '0;
      step_q      <= '0;
      sub_q       <= '0;
    end else begin
      state_q <= state_d;
      if (accept_start) begin
        chunk_num_q <= chunk_num_sat;
        sub_q       <= sub_channel_size_i;
        step_q      <= step_calc;
        y_q         <= '0;
        chunk_q     <= '0;
      end
      if (state_q == ADV) begin
        if (y_last) begin
          y_q     <= '0;
          chunk_q <= chunk_inc;
        end else begin
          y_q <= y_q + 1'b1;
        end
      end
    end
  end

  fil_window_calc u_fil_window_calc (
    .y         (y_q),
    .fil_start (fil_loop_y_idx_start_o),
    .fil_last  (fil_loop_y_idx_last_o)
  );

  // Output decode; indices come straight from registers so they hold during WAIT.
  always_comb begin
    inner_loop_start_o = (state_q == START);
    layer_done_o       = (state_q == DONE);
    busy_o             = (state_q != IDLE);
    ifm_loop_y_idx_o   = y_q;
    chunk_idx_o        = chunk_q;
    fil_loop_y_step_o  = step_q;
    sub_channel_size_o = sub_q;
  end

`ifdef OUTER_LOOP_STALL_CNT_EN
  logic [31:0] stall_q;

  // Saturating count of WAIT cycles, restarted by each accepted layer.
  always_ff @(posedge clk_i) begin
    if (rst_i || accept_start) stall_q <= '0;
    else if ((state_q == WAIT) && (stall_q != '1)) stall_q <= stall_q + 32'd1;
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_stacking_outer_loop.sv
// Self-checking bench for stacking_outer_loop; acts as the inner loop.
module tb_stacking_outer_loop;
  import stacking_pkg::*;

  logic               clk = 1'b0;
  logic               rst, layer_start, finish;
  logic [CHUNK_W-1:0] chunk_num;
  logic [SUB_W-1:0]   sub;
  logic               inner_loop_start_o, busy_o, layer_done_o;
  logic [Y_W-1:0]     ifm_loop_y_idx_o, fil_loop_y_idx_start_o, fil_loop_y_idx_last_o;
  logic [STEP_W-1:0]  fil_loop_y_step_o;
  logic [SUB_W-1:0]   sub_channel_size_o;
  logic [CHUNK_W-1:0] chunk_idx_o;
`ifdef OUTER_LOOP_STALL_CNT_EN
  logic [31:0]        stall_cnt_o;
`endif

  always #5 clk = ~clk;

  stacking_outer_loop dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .layer_start_i          (layer_start),
    .chunk_num_i            (chunk_num),
    .sub_channel_size_i     (sub),
    .inner_loop_finish_i    (finish),
    .inner_loop_start_o     (inner_loop_start_o),
    .ifm_loop_y_idx_o       (ifm_loop_y_idx_o),
    .fil_loop_y_idx_start_o (fil_loop_y_idx_start_o),
    .fil_loop_y_idx_last_o  (fil_loop_y_idx_last_o),
    .fil_loop_y_step_o      (fil_loop_y_step_o),
    .sub_channel_size_o     (sub_channel_size_o),
    .chunk_idx_o            (chunk_idx_o),
    .busy_o                 (busy_o),
    .layer_done_o           (layer_done_o)
`ifdef OUTER_LOOP_STALL_CNT_EN
    ,
    .stall_cnt_o            (stall_cnt_o)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: the ordered list of launches a layer must produce.
  typedef struct {
    int y;
    int fs;
    int fl;
    int ch;
  } launch_t;

  launch_t exp_q[$];
  int      exp_step, exp_sub;
  int      log_y[$], log_s[$], log_l[$];
  launch_t cur;
  bit      wait_active = 1'b0;

  function automatic void build_model(input int chunks, input int subc);
    int cn, prod, q;
    launch_t t;
    cn = (chunks > CHUNK_NUM_MAX) ? CHUNK_NUM_MAX : chunks;
    exp_q.delete();
    for (int c = 0; c < cn; c++)
      for (int y = 0; y < IFM_SIZE_Y; y++) begin
        t.y  = y;
        t.fs = (y > OUT_Y - 1) ? y - (OUT_Y - 1) : 0;
        t.fl = (y < FILTER_SIZE_Y - 1) ? y : FILTER_SIZE_Y - 1;
        t.ch = c;
        exp_q.push_back(t);
      end
    prod = FILTER_SIZE_X * subc;
    q    = prod / PREFIX_SUM_SIZE;
    if (q * PREFIX_SUM_SIZE < prod) q++;
    exp_step = (subc == 0) ? 1 : q;
    exp_sub  = subc;
  endfunction

  // Compare process: each launch against the model, and index stability in WAIT.
  always @(negedge clk) begin
    if (inner_loop_start_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL extra_start: got start at y=%0d chunk=%0d expected none",
                 ifm_loop_y_idx_o, chunk_idx_o);
      end else begin
        cur = exp_q.pop_front();
        check("launch_y", ifm_loop_y_idx_o, cur.y);
        check("launch_fil_start", fil_loop_y_idx_start_o, cur.fs);
        check("launch_fil_last", fil_loop_y_idx_last_o, cur.fl);
        check("launch_chunk", chunk_idx_o, cur.ch);
        check("launch_step", fil_loop_y_step_o, exp_step);
        check("launch_sub", sub_channel_size_o, exp_sub);
      end
    end else if (wait_active) begin
      check("wait_y_stable", ifm_loop_y_idx_o, cur.y);
      check("wait_fil_start_stable", fil_loop_y_idx_start_o, cur.fs);
      check("wait_fil_last_stable", fil_loop_y_idx_last_o, cur.fl);
      check("wait_chunk_stable", chunk_idx_o, cur.ch);
      check("wait_busy", busy_o, 1);
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_start"}, inner_loop_start_o, 0);
    check({tag, "_y"}, ifm_loop_y_idx_o, 0);
    check({tag, "_fs"}, fil_loop_y_idx_start_o, 0);
    check({tag, "_fl"}, fil_loop_y_idx_last_o, 0);
    check({tag, "_step"}, fil_loop_y_step_o, 0);
    check({tag, "_sub"}, sub_channel_size_o, 0);
    check({tag, "_chunk"}, chunk_idx_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, layer_done_o, 0);
`ifdef OUTER_LOOP_STALL_CNT_EN
    check({tag, "_stall"}, stall_cnt_o, 0);
`endif
  endtask

  int last_starts;

  // Runs one layer. dly<=0 picks a random finish delay per launch; rst_y>=0
  // aborts with a reset during the WAIT of that row in chunk 0.
  task automatic run_layer(input int chunks, input int subc, input int dly,
                           input bit stray, input int rst_y);
    int  cn, wcnt, since_fin, d, total_wait;
    bit  done_seen, fin_now, rst_pending, aborted;
    cn = (chunks > CHUNK_NUM_MAX) ? CHUNK_NUM_MAX : chunks;
    build_model(chunks, subc);
    log_y.delete(); log_s.delete(); log_l.delete();
    @(negedge clk); #1;
    layer_start = 1'b1;
    chunk_num   = CHUNK_W'(chunks);
    sub         = SUB_W'(subc);
    @(negedge clk); #1;
    layer_start = 1'b0;
    if (cn == 0) begin
      check("zero_chunk_done_latency", layer_done_o, 1);
      check("zero_chunk_no_start", inner_loop_start_o, 0);
    end else begin
      check("start_latency", inner_loop_start_o, 1);
    end
    check("busy_after_start", busy_o, 1);
`ifdef OUTER_LOOP_STALL_CNT_EN
    check("stall_cleared_on_start", stall_cnt_o, 0);
`endif
    last_starts = 0; wcnt = -1; since_fin = -1; d = 1; total_wait = 0;
    done_seen = 1'b0; rst_pending = 1'b0; aborted = 1'b0;
    for (int cyc = 0; cyc < 4000 && !done_seen; cyc++) begin
      if (rst_pending) begin
        wait_active = 1'b0;
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        check_all_zero("reset_in_wait");
        exp_q.delete();
        aborted = 1'b1;
        break;
      end
      fin_now     = 1'b0;
      layer_start = 1'b0;
      chunk_num   = CHUNK_W'(chunks);
      sub         = SUB_W'(subc);
      if (inner_loop_start_o) begin
        if (since_fin >= 0) check("finish_to_start", since_fin, 2);
        since_fin = -1;
        last_starts++;
        log_y.push_back(int'(ifm_loop_y_idx_o));
        log_s.push_back(int'(fil_loop_y_idx_start_o));
        log_l.push_back(int'(fil_loop_y_idx_last_o));
        d = (dly > 0) ? dly : int'($urandom_range(1, 6));
        wcnt = d;
        total_wait += d;
        wait_active = 1'b1;
        if (stray) fin_now = 1'b1;
        if (rst_y >= 0 && int'(ifm_loop_y_idx_o) == rst_y && chunk_idx_o == '0)
          rst_pending = 1'b1;
      end else if (wcnt > 0) begin
        wcnt--;
        if (stray && wcnt == d - 1) begin
          layer_start = 1'b1;
          chunk_num   = '0;
          sub         = SUB_W'(subc + 3);
        end
        if (wcnt == 0) begin
          fin_now     = 1'b1;
          since_fin   = 0;
          wait_active = 1'b0;
        end
      end else if (stray && since_fin == 1) begin
        fin_now = 1'b1;
      end
      if (layer_done_o) begin
        done_seen = 1'b1;
        if (cn > 0) check("finish_to_done", since_fin, 2);
      end else begin
        check("busy_while_active", busy_o, 1);
      end
      finish = fin_now;
      @(negedge clk); #1;
      if (since_fin >= 0) since_fin++;
    end
    finish = 1'b0;
    layer_start = 1'b0;
    if (!aborted) begin
      check("layer_done_seen", done_seen, 1);
      check("start_count", last_starts, cn * IFM_SIZE_Y);
      check("model_drained", exp_q.size(), 0);
      check("busy_low_after_done", busy_o, 0);
      check("done_single_pulse", layer_done_o, 0);
      check("step_after_done", fil_loop_y_step_o, exp_step);
      check("sub_after_done", sub_channel_size_o, exp_sub);
`ifdef OUTER_LOOP_STALL_CNT_EN
      check("stall_total", stall_cnt_o, total_wait);
`endif
      if (stray) begin
        finish = 1'b1;
        @(negedge clk); #1;
        finish = 1'b0;
        check("idle_finish_no_start", inner_loop_start_o, 0);
        check("idle_finish_no_busy", busy_o, 0);
      end
    end
  endtask

  int lit_y[7] = '{0, 1, 2, 3, 4, 5, 6};
  int lit_s[7] = '{0, 0, 0, 0, 0, 1, 2};
  int lit_l[7] = '{0, 1, 2, 2, 2, 2, 2};

  initial begin
    rst = 1'b1; layer_start = 1'b0; finish = 1'b0; chunk_num = '0; sub = '0;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Default layer: one chunk, full sub-channel, finish 3 cycles after start.
    run_layer(1, 32, 3, 1'b0, -1);
    check("t1_start_count_literal", log_y.size(), 7);
    for (int i = 0; i < 7; i++) begin
      check("t1_y_literal", log_y[i], lit_y[i]);
      check("t1_fil_start_literal", log_s[i], lit_s[i]);
      check("t1_fil_last_literal", log_l[i], lit_l[i]);
    end
    check("t1_step_literal", fil_loop_y_step_o, 12);

    // Two chunks, 20 channels.
    run_layer(2, 20, 0, 1'b0, -1);
    check("t2_starts_literal", last_starts, 14);
    check("t2_step_literal", fil_loop_y_step_o, 8);

    // Empty layer.
    run_layer(0, 5, 1, 1'b0, -1);

    // Stray inputs and a 20-cycle WAIT.
    run_layer(1, 8, 20, 1'b1, -1);
    check("t4_step_literal", fil_loop_y_step_o, 3);

    // Zero sub-channel size forces the step to one.
    run_layer(1, 0, 2, 1'b0, -1);
    check("t5_step_literal", fil_loop_y_step_o, 1);

    // Reset during WAIT of row 3, then a clean restart.
    run_layer(2, 16, 4, 1'b0, 3);
    run_layer(1, 16, 2, 1'b0, -1);

    // Five WAIT cycles per launch.
    run_layer(1, 32, 5, 1'b0, -1);
`ifdef OUTER_LOOP_STALL_CNT_EN
    check("t7_stall_literal", stall_cnt_o, 35);
`endif

    // Chunk count above the maximum saturates.
    run_layer(20, 12, 1, 1'b0, -1);
    check("t8_saturated_starts", last_starts, CHUNK_NUM_MAX * IFM_SIZE_Y);

    // Randomised layers.
    for (int k = 0; k < 6; k++)
      run_layer(int'($urandom_range(1, 3)), int'($urandom_range(0, 40)), 0,
                1'($urandom_range(0, 1)), -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
